// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared constants and encodings for the fetch stage
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_REG    = 2'd3
    } pc_src_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// rtl/instruction_fetch_if_id_reg.sv - IF/ID pipeline register, flush beats stall
module if_id_reg
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = TEXT_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_plus4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush_i) begin
            // Bubble still carries PC+4 so a later branch sees a sane base.
            instr_d    = NOP_INSTR;
            pc_plus4_d = pc_plus4_i;
            valid_d    = 1'b0;
        end else if (!stall_i) begin
            instr_d    = instr_i;
            pc_plus4_d = pc_plus4_i;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= RESET_PC;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC register, next-PC select, IF/ID and fetch counter
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = TEXT_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  pc_src,
    input  logic [15:0] branch_imm,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        fetch_accept;

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = if_id_pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
    assign jump_target   = {if_id_pc_plus4[31:28], jump_index, 2'b00};

    // A redirect resolved in ID must land even during a load-use stall.
    always_comb begin
        pc_d = pc_plus4;
        case (pc_src_e'(pc_src))
            PC_BRANCH: pc_d = branch_target;
            PC_JUMP:   pc_d = jump_target;
            PC_REG:    pc_d = jr_target;
            default:   pc_d = stall ? pc_q : pc_plus4;
        endcase
    end

    assign fetch_accept = !flush && !stall;
    assign count_d      = fetch_accept ? count_q + 32'd1 : count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            count_q <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    if_id_reg #(
        .RESET_PC(RESET_PC)
    ) u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .stall_i    (stall),
        .flush_i    (flush),
        .instr_i    (imem_instr),
        .pc_plus4_i (pc_plus4),
        .instr_o    (if_id_instr),
        .pc_plus4_o (if_id_pc_plus4),
        .valid_o    (if_id_valid)
    );

    assign imem_addr   = pc_q;
    assign fetch_count = count_q;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage of the pipelined MIPS core: owns the program counter, drives the word address into the combinational instruction memory, and registers the returned word with its PC+4 into the IF/ID pipeline register. Next-PC selection (sequential, conditional branch, J/JAL, JR/JALR) uses redirect requests resolved in ID. Stall and flush come from the hazard unit. A fetch counter is provided for performance checks.

## Interface
- `RESET_PC`, default `32'h0040_0000`: PC value loaded on reset; text segment base.
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-high; all state forced to reset values immediately.
- `stall`, input, 1: hold the PC and IF/ID contents (load-use hazard).
- `flush`, input, 1: load a bubble into IF/ID on the next edge.
- `pc_src`, input, 2: next-PC select. 0 = PC+4, 1 = branch, 2 = jump, 3 = register.
- `branch_imm`, input, 16: signed branch offset in words, from the ID instruction.
- `jump_index`, input, 26: J-type instruction index, from the ID instruction.
- `jr_target`, input, 32: register target for JR/JALR, forwarded from ID.
- `imem_addr`, output, 32: byte address presented to instruction memory; equal to the PC register.
- `imem_instr`, input, 32: instruction word returned combinationally for `imem_addr`.
- `if_id_instr`, output, 32: registered instruction; reset value `32'h0000_0000` (NOP).
- `if_id_pc_plus4`, output, 32: registered PC+4 of that instruction; reset value `RESET_PC`.
- `if_id_valid`, output, 1: IF/ID holds a real instruction; reset value 0.
- `fetch_count`, output, 32: number of instructions accepted into IF/ID; reset value 0.

## Operation
- PC register reset value is `RESET_PC`, so `imem_addr` = `RESET_PC` while reset is asserted.
- Next-PC candidates; all sums wrap modulo 2^32:
  - seq = PC + 4.
  - branch = `if_id_pc_plus4` + (sign-extend(`branch_imm`) << 2).
  - jump = {`if_id_pc_plus4`[31:28], `jump_index`, 2'b00}.
  - register = `jr_target`, used unmodified. Misaligned values are passed through and are not checked.
- PC update priority each edge:
  1. `reset`.
  2. `pc_src` != 0: load the selected target. A redirect wins over `stall`.
  3. `stall`: hold the PC.
  4. Otherwise load seq.
- IF/ID update priority each edge:
  1. `reset`.
  2. `flush`: instr ← NOP, valid ← 0, pc_plus4 ← PC+4. This wins over `stall`.
  3. `stall`: hold all three fields.
  4. Otherwise instr ← `imem_instr`, pc_plus4 ← PC+4, valid ← 1.
- The hazard unit asserts `flush` together with every taken redirect, so the wrong-path word fetched in that cycle is squashed. The block does not infer the flush itself.
- `fetch_count` increments by 1 on every edge that loads IF/ID through case 4 above. It wraps from `32'hFFFF_FFFF` to 0.
- `pc_src` is ignored while `reset` is high.

## Timing
- Fetch latency is 1 cycle. The PC is visible on `imem_addr` in cycle N, and the word appears on `if_id_instr` after the edge ending cycle N.
- Redirect penalty is 1 bubble. A redirect in cycle N puts the target on `imem_addr` in cycle N+1, and IF/ID shows a NOP with `if_id_valid` = 0 in cycle N+1.
- Stall is level-sensitive. For each stalled cycle, the PC and IF/ID are held, `fetch_count` is unchanged, and `imem_addr` is constant.
- Reset asserted mid-stream (asynchronous): outputs reach their reset values without waiting for a clock edge. After deassertion, the first edge captures the word at `RESET_PC`.

## Structure
- Shared package holds:
  - The `pc_src` encodings: PC_SEQ = 0, PC_BRANCH = 1, PC_JUMP = 2, PC_REG = 3.
  - The NOP constant.
  - The default text base `32'h0040_0000`.
- One natural sub-module: `if_id_reg`, the IF/ID pipeline register with its flush/stall priority. The PC, next-PC mux and fetch counter stay in the top level.

## Test plan
- Reset release with no stall or redirect, 3 edges:
  - `imem_addr` steps 0x00400000 → 0x00400004 → 0x00400008.
  - `if_id_pc_plus4` = 0x00400004, then 0x00400008.
  - `fetch_count` reaches 3.
- `stall` held for 2 cycles at PC 0x00400010: `imem_addr` and the IF/ID fields stay frozen and `fetch_count` does not change. Fetch resumes at 0x00400014.
- Branch with `if_id_pc_plus4` = 0x00400040 and `branch_imm` = 0xFFFC (−4), with `pc_src` = 1 and `flush` = 1:
  - Next `imem_addr` = 0x00400030.
  - IF/ID = NOP with valid = 0.
  - Count is not incremented for the bubble.
- Jump with `jump_index` = 0x0100020 and `if_id_pc_plus4` = 0x00400090: next PC = 0x00400080.
- `pc_src` = 3 with `jr_target` = 0x00400094 while `stall` = 1: the PC still loads 0x00400094, because redirect beats stall.
- `reset` pulsed asynchronously between edges while at PC 0x00400050: the PC returns to 0x00400000, IF/ID returns to its reset values, and `fetch_count` = 0 immediately.
